// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
// Shares one 7-segment display between three value sources (operand A,
// operand B, sum). A round-robin arbiter picks one requesting source and
// latches its value, clamped to 0..9999. The value is then shown for at least
// HOLD_CYCLES clock cycles before another source can take the display.
//
// Ports
//   clk_i    : system clock, rising edge
//   rst_i    : asynchronous reset, active low
//   req_i    : level request per source (bit0 A, bit1 B, bit2 sum)
//   data0_i  : value offered by source 0
//   data1_i  : value offered by source 1
//   data2_i  : value offered by source 2
//   grant_o  : one-hot current display owner (000 before the first grant)
//   ack_o    : one-cycle pulse on the bit of the source whose data was latched
//   bin_o    : registered display value, always 0..9999
//   ovf_o    : high while bin_o holds a clamped value
//   busy_o   : high while a grant is being held on the display
// -----------------------------------------------------------------------------
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 27000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  req_i,
  input  logic [15:0] data0_i,
  input  logic [15:0] data1_i,
  input  logic [15:0] data2_i,
  output logic [2:0]  grant_o,
  output logic [2:0]  ack_o,
  output logic [15:0] bin_o,
  output logic        ovf_o,
  output logic        busy_o
);

  // Counter only needs to reach HOLD_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      BIN_MAX  = 16'd9999;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       last_r;
  logic [2:0]       grant_r;
  logic [2:0]       ack_r;
  logic [15:0]      bin_r;
  logic             ovf_r;
  logic             busy_r;

  logic [1:0]       win_idx_s;
  logic [2:0]       win_hot_s;
  logic [15:0]      win_data_s;

  // Round-robin pick: search starts one past the last winner and wraps.
  // Caller guarantees at least one request bit is set when the result is used.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    idx = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      idx = 2'd1;
        else if (req[2]) idx = 2'd2;
        else             idx = 2'd0;
      end
      2'd1: begin
        if (req[2])      idx = 2'd2;
        else if (req[0]) idx = 2'd0;
        else             idx = 2'd1;
      end
      default: begin
        if (req[0])      idx = 2'd0;
        else if (req[1]) idx = 2'd1;
        else             idx = 2'd2;
      end
    endcase
    return idx;
  endfunction

  // Clamp a source value into the four-digit display range.
  function automatic logic [15:0] sat_bin(input logic [15:0] d);
    return (d > BIN_MAX) ? BIN_MAX : d;
  endfunction

  // Winner selection and its data mux.
  always_comb begin
    win_idx_s  = rr_pick(req_i, last_r);
    win_hot_s  = 3'b001 << win_idx_s;
    win_data_s = data0_i;
    case (win_idx_s)
      2'd0:    win_data_s = data0_i;
      2'd1:    win_data_s = data1_i;
      2'd2:    win_data_s = data2_i;
      default: win_data_s = data0_i;
    endcase
  end

  // Arbiter state machine with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      last_r  <= 2'd2;
      grant_r <= 3'b000;
      ack_r   <= 3'b000;
      bin_r   <= 16'd0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ack_r <= 3'b000;
      case (state_r)
        IDLE: begin
          if (|req_i) begin
            state_r <= HOLD;
            cnt_r   <= CNT_LOAD;
            last_r  <= win_idx_s;
            grant_r <= win_hot_s;
            ack_r   <= win_hot_s;
            bin_r   <= sat_bin(win_data_s);
            ovf_r   <= (win_data_s > BIN_MAX);
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        HOLD: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else if (|req_i) begin
            // Back-to-back grant keeps busy_o high without a gap.
            state_r <= HOLD;
            cnt_r   <= CNT_LOAD;
            last_r  <= win_idx_s;
            grant_r <= win_hot_s;
            ack_r   <= win_hot_s;
            bin_r   <= sat_bin(win_data_s);
            ovf_r   <= (win_data_s > BIN_MAX);
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o = grant_r;
  assign ack_o   = ack_r;
  assign bin_o   = bin_r;
  assign ovf_o   = ovf_r;
  assign busy_o  = busy_r;

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
// Directed self-checking bench for display_arbiter with HOLD_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_display_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic [2:0]  req_i;
  logic [15:0] data0_i;
  logic [15:0] data1_i;
  logic [15:0] data2_i;
  logic [2:0]  grant_o;
  logic [2:0]  ack_o;
  logic [15:0] bin_o;
  logic        ovf_o;
  logic        busy_o;

  int checks;
  int errors;

  display_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .data0_i (data0_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .grant_o (grant_o),
    .ack_o   (ack_o),
    .bin_o   (bin_o),
    .ovf_o   (ovf_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant_o), 32'd0);
    chk({tag, "_ack"},   32'(ack_o),   32'd0);
    chk({tag, "_bin"},   32'(bin_o),   32'd0);
    chk({tag, "_ovf"},   32'(ovf_o),   32'd0);
    chk({tag, "_busy"},  32'(busy_o),  32'd0);
  endtask

  // One source requests alone; check the grant, then the 4-cycle hold and IDLE.
  task automatic single(input string tag, input logic [2:0] bitv,
                        input logic [15:0] exp_bin, input logic exp_ovf);
    int busy_cnt;
    req_i = bitv;
    tick();
    chk({tag, "_grant"}, 32'(grant_o), 32'(bitv));
    chk({tag, "_ack"},   32'(ack_o),   32'(bitv));
    chk({tag, "_bin"},   32'(bin_o),   32'(exp_bin));
    chk({tag, "_ovf"},   32'(ovf_o),   32'(exp_ovf));
    req_i = 3'b000;
    busy_cnt = (busy_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy_o === 1'b1) busy_cnt++;
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    chk({tag, "_idle"},        32'(busy_o),   32'd0);
    chk({tag, "_held_bin"},    32'(bin_o),    32'(exp_bin));
    chk({tag, "_held_grant"},  32'(grant_o),  32'(bitv));
  endtask

  initial begin
    logic [2:0] exp_g;
    checks  = 0;
    errors  = 0;
    rst_i   = 1'b0;
    req_i   = 3'b111;
    data0_i = 16'hA5A5;
    data1_i = 16'h1234;
    data2_i = 16'hFFFF;

    // Reset with arbitrary inputs, then release with no requests.
    tick();
    tick();
    chk_zero("rst_held");
    req_i = 3'b000;
    rst_i = 1'b1;
    tick();
    tick();
    chk_zero("rst_release");

    // Contention: all three request, each drops after its own ack.
    data0_i = 16'd100;
    data1_i = 16'd200;
    data2_i = 16'd300;
    req_i   = 3'b111;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("cont_busy", 32'(busy_o), 32'd1);
      if ((i % 4) == 0) begin
        exp_g = 3'b001 << (i / 4);
        chk("cont_grant", 32'(grant_o), 32'(exp_g));
        chk("cont_ack",   32'(ack_o),   32'(exp_g));
        chk("cont_bin",   32'(bin_o),   32'(16'd100 * 16'((i / 4) + 1)));
        req_i = req_i & ~exp_g;
      end else begin
        chk("cont_ack_quiet", 32'(ack_o), 32'd0);
      end
    end
    tick();
    chk("cont_idle", 32'(busy_o), 32'd0);
    chk("cont_last_grant", 32'(grant_o), 32'd4);

    // Single request from source 1.
    data1_i = 16'd1234;
    single("single_b", 3'b010, 16'd1234, 1'b0);

    // Saturation sequence on source 0.
    data0_i = 16'hFFFF;
    single("sat_ffff", 3'b001, 16'd9999, 1'b1);
    data0_i = 16'd9999;
    single("sat_9999", 3'b001, 16'd9999, 1'b0);
    data0_i = 16'd10000;
    single("sat_10000", 3'b001, 16'd9999, 1'b1);
    data0_i = 16'd0;
    single("sat_zero", 3'b001, 16'd0, 1'b0);

    // Dropped request: bit2 pulses for two cycles during source 0's hold.
    data0_i = 16'd55;
    data2_i = 16'd77;
    req_i   = 3'b001;
    tick();
    chk("drop_grant", 32'(grant_o), 32'd1);
    req_i = 3'b100;
    tick();
    chk("drop_ack1", 32'(ack_o), 32'd0);
    tick();
    chk("drop_ack2", 32'(ack_o), 32'd0);
    req_i = 3'b000;
    tick();
    chk("drop_ack3", 32'(ack_o), 32'd0);
    chk("drop_busy3", 32'(busy_o), 32'd1);
    tick();
    chk("drop_idle", 32'(busy_o), 32'd0);
    chk("drop_bin", 32'(bin_o), 32'd55);
    chk("drop_grant_held", 32'(grant_o), 32'd1);
    tick();
    chk("drop_no_late_ack", 32'(ack_o), 32'd0);

    // Reset mid-hold (counter = 2), then source 0 must win first again.
    data0_i = 16'd7;
    req_i   = 3'b001;
    tick();
    chk("mid_grant", 32'(grant_o), 32'd1);
    req_i = 3'b000;
    tick();
    chk("mid_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk_zero("mid_async");
    data0_i = 16'd11;
    data1_i = 16'd22;
    data2_i = 16'd33;
    req_i   = 3'b111;
    tick();
    chk_zero("mid_in_reset");
    rst_i = 1'b1;
    tick();
    chk("mid_first_grant", 32'(grant_o), 32'd1);
    chk("mid_first_ack",   32'(ack_o),   32'd1);
    chk("mid_first_bin",   32'(bin_o),   32'd11);
    req_i = 3'b000;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_idle", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
